// File: rtl/mux_rr_sel_arbiter_if.sv
// mux_rr_sel_arbiter_if: request/grant bundle between four sources and the mux steering arbiter
interface mux_rr_sel_arbiter_if;
  logic [3:0] req;
  logic       en;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  modport master (output req, input en, sel, gnt, busy);
  modport slave (input req, output en, sel, gnt, busy);
endinterface

// File: rtl/mux_rr_sel_arbiter.sv
// mux_rr_sel_arbiter: round-robin en/sel driver for a 4:1 enabled mux; RR_GAP_EN adds a dead cycle between grants
module mux_rr_sel_arbiter #(
  parameter int HOLD_CYCLES = 8
) (
  input logic clk,
  input logic rst_n,
  mux_rr_sel_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
`ifdef RR_GAP_EN
  localparam logic [1:0] GAP = 2'd2;
`endif
  logic [1:0] state, sel_q, last, base, win;
  logic [CNT_W-1:0] cnt;
  logic rel;
  assign bus.en = state == GRANT;
  assign bus.sel = sel_q;
  assign bus.gnt = bus.en ? 4'b0001 << sel_q : 4'b0000;
  assign bus.busy = state != IDLE;
  assign rel = state == GRANT && (!bus.req[sel_q] || cnt == CNT_W'(HOLD_CYCLES - 1));
  // while granted, the current owner becomes "last" so it ends up lowest priority
  always_comb begin
    base = state == GRANT ? sel_q : last;
    win = base;
    for (int i = 4; i >= 1; i--) if (bus.req[2'(base + 2'(i))]) win = 2'(base + 2'(i));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= 2'b00;
      cnt <= '0;
      last <= 2'd3;
    end else if (state == GRANT && !rel) begin
      cnt <= cnt + 1'b1;
    end else if (rel) begin
      last <= sel_q;
`ifdef RR_GAP_EN
      state <= GAP;
`else
      if (|bus.req) begin
        sel_q <= win;
        cnt <= '0;
      end else begin
        state <= IDLE;
      end
`endif
    end else if (|bus.req) begin
      state <= GRANT;
      sel_q <= win;
      cnt <= '0;
    end else begin
      state <= IDLE;
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) bus.en |-> ($onehot(bus.gnt) && bus.gnt[sel_q]));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n) bus.en |-> cnt <= CNT_W'(HOLD_CYCLES - 1));
endmodule
